// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage next-PC generator with bimodal direction predictor and BTB update
// Optional macro FETCH_PERF_COUNTERS_EN adds resolved-branch and mispredict counters.

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PHT_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  output logic        mispredict,
  output logic        btb_update,
  output logic [31:0] btb_update_pc,
  output logic [31:0] btb_update_target,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);
  localparam int PHT_SIZE = 1 << PHT_BITS;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_REDIRECT} state_t;

  state_t              r_state;
  logic                r_fetch_valid;
  logic [31:0]         r_pc;
  logic [1:0]          r_pht [PHT_SIZE];
  logic                r_btb_update;
  logic [31:0]         r_btb_update_pc;
  logic [31:0]         r_btb_update_target;

  logic [PHT_BITS-1:0] w_lookup_idx;
  logic [PHT_BITS-1:0] w_update_idx;
  logic [1:0]          w_lookup_cnt;
  logic [1:0]          w_update_cnt;
  logic                w_pred_taken;
  logic [31:0]         w_pred_next_pc;
  logic [31:0]         w_correct_pc;
  logic                w_mispredict;

  assign w_lookup_idx   = r_pc[PHT_BITS+1:2];
  assign w_update_idx   = resolve_pc[PHT_BITS+1:2];
  assign w_lookup_cnt   = r_pht[w_lookup_idx];
  assign w_update_cnt   = r_pht[w_update_idx];

  assign w_pred_taken   = btb_hit && w_lookup_cnt[1];
  assign w_pred_next_pc = w_pred_taken ? btb_target : r_pc + 32'd4;

  // Comparing the carried predicted next PC against the true next PC also
  // catches a not-taken branch that was sent down a stale target.
  assign w_correct_pc   = resolve_taken ? resolve_target : resolve_pc + 32'd4;
  assign w_mispredict   = !reset && resolve_valid &&
                          ((resolve_taken != resolve_pred_taken) ||
                           (resolve_pred_target != w_correct_pc));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_state       <= ST_BOOT;
      r_fetch_valid <= 1'b0;
    end else begin
      if (w_mispredict)
        r_pc <= w_correct_pc;
      else if (!stall && r_fetch_valid)
        r_pc <= w_pred_next_pc;

      // A redirect always costs one bubble so the new PC can reach the BTB.
      case (r_state)
        ST_RUN: begin
          if (w_mispredict) begin
            r_state       <= ST_REDIRECT;
            r_fetch_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= w_mispredict ? ST_REDIRECT : ST_RUN;
          r_fetch_valid <= !w_mispredict;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++)
        r_pht[i[PHT_BITS-1:0]] <= 2'b01;
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (w_update_cnt != 2'b11)
          r_pht[w_update_idx] <= w_update_cnt + 2'd1;
      end else if (w_update_cnt != 2'b00) begin
        r_pht[w_update_idx] <= w_update_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_update        <= 1'b0;
      r_btb_update_pc     <= '0;
      r_btb_update_target <= '0;
    end else begin
      r_btb_update <= resolve_valid && resolve_taken;
      if (resolve_valid && resolve_taken) begin
        r_btb_update_pc     <= resolve_pc;
        r_btb_update_target <= resolve_target;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (resolve_valid)
        r_perf_branches <= r_perf_branches + 32'd1;
      if (w_mispredict)
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

  assign pc_out            = r_pc;
  assign fetch_valid       = r_fetch_valid;
  assign pred_taken        = w_pred_taken;
  assign pred_next_pc      = w_pred_next_pc;
  assign mispredict        = w_mispredict;
  assign btb_update        = r_btb_update;
  assign btb_update_pc     = r_btb_update_pc;
  assign btb_update_target = r_btb_update_target;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
// Directed scenarios plus randomized traffic against a behavioural reference model.

module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, btb_hit, resolve_valid, resolve_taken, resolve_pred_taken;
  logic [31:0] btb_target, resolve_pc, resolve_target, resolve_pred_target;
  logic [31:0] pc_out, pred_next_pc, btb_update_pc, btb_update_target;
  logic [31:0] perf_branches, perf_mispredicts;
  logic        fetch_valid, pred_taken, mispredict, btb_update;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc, m_upd_pc, m_upd_tgt, m_branches, m_mispredicts;
  bit          m_fv, m_upd;
  int          m_cnt [64];

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .btb_hit(btb_hit), .btb_target(btb_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
    .resolve_pred_target(resolve_pred_target), .pc_out(pc_out), .fetch_valid(fetch_valid),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc), .mispredict(mispredict),
    .btb_update(btb_update), .btb_update_pc(btb_update_pc), .btb_update_target(btb_update_target),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) % 32'd64);
  endfunction

  function automatic logic [31:0] exp_correct();
    return resolve_taken ? resolve_target : resolve_pc + 32'd4;
  endfunction

  function automatic bit exp_mp();
    return resolve_valid && ((resolve_taken != resolve_pred_taken) || (resolve_pred_target != exp_correct()));
  endfunction

  function automatic bit exp_pt();
    return btb_hit && (m_cnt[idx(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] exp_pnext();
    return exp_pt() ? btb_target : m_pc + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; btb_hit = 0; btb_target = 0; resolve_valid = 0; resolve_pc = 0;
    resolve_taken = 0; resolve_target = 0; resolve_pred_taken = 0; resolve_pred_target = 0;
  endtask

  task automatic set_resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt);
    resolve_valid = 1; resolve_pc = pc; resolve_taken = tk; resolve_target = tgt;
    resolve_pred_taken = ptk; resolve_pred_target = ptgt;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    m_pc = 0; m_fv = 0; m_upd = 0; m_upd_pc = 0; m_upd_tgt = 0; m_branches = 0; m_mispredicts = 0;
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
  endtask

  task automatic model_step();
    logic [31:0] corr, pnext;
    bit mp;
    int ui;
    corr  = exp_correct();
    mp    = exp_mp();
    pnext = exp_pnext();
    if (mp) m_pc = corr;
    else if (!stall && m_fv) m_pc = pnext;
    m_fv = !mp;
    if (resolve_valid) begin
      ui = idx(resolve_pc);
      if (resolve_taken) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
      else               m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
      m_branches = m_branches + 1;
    end
    if (mp) m_mispredicts = m_mispredicts + 1;
    m_upd = resolve_valid && resolve_taken;
    if (m_upd) begin
      m_upd_pc  = resolve_pc;
      m_upd_tgt = resolve_target;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    set_resolve(32'h40, 1, 32'h200, 0, 32'h44);
    tick();
    tick();
    n_checks++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 0", pc_out); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL rst_fv got %b exp 0", fetch_valid); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL rst_mp got %b exp 0", mispredict); else n_pass++;
    n_checks++; if (btb_update !== 1'b0) $display("FAIL rst_upd got %b exp 0", btb_update); else n_pass++;
    idle_inputs();
    reset = 0;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL boot_fv got %b exp 0", fetch_valid); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (fetch_valid !== 1'b1) $display("FAIL seq_fv[%0d] got %b exp 1", k, fetch_valid); else n_pass++;
      n_checks++; if (pc_out !== 32'(4 * k)) $display("FAIL seq_pc[%0d] got %h exp %h", k, pc_out, 4 * k); else n_pass++;
    end
    // Reset arriving with a mispredict pending must win.
    set_resolve(32'h40, 1, 32'h200, 0, 32'h44);
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    n_checks++; if (pc_out !== 32'h0) $display("FAIL rst_mid_pc got %h exp 0", pc_out); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL rst_mid_fv got %b exp 0", fetch_valid); else n_pass++;
    n_checks++; if (btb_update !== 1'b0) $display("FAIL rst_mid_upd got %b exp 0", btb_update); else n_pass++;
  endtask

  task automatic test_btb_predict();
    do_reset();
    tick();
    repeat (8) tick();
    n_checks++; if (pc_out !== 32'h20) $display("FAIL bp_pc got %h exp 20", pc_out); else n_pass++;
    btb_hit = 1; btb_target = 32'h100;
    #1;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL bp_pt0 got %b exp 0", pred_taken); else n_pass++;
    n_checks++; if (pred_next_pc !== 32'h24) $display("FAIL bp_pn0 got %h exp 24", pred_next_pc); else n_pass++;
    stall = 1;
    set_resolve(32'h20, 1, 32'h100, 1, 32'h100);
    #1;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL bp_nomp got %b exp 0", mispredict); else n_pass++;
    tick();
    tick();
    resolve_valid = 0;
    #1;
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL bp_pt1 got %b exp 1", pred_taken); else n_pass++;
    n_checks++; if (pred_next_pc !== 32'h100) $display("FAIL bp_pn1 got %h exp 100", pred_next_pc); else n_pass++;
    stall = 0;
    tick();
    n_checks++; if (pc_out !== 32'h100) $display("FAIL bp_jump got %h exp 100", pc_out); else n_pass++;
    n_checks++; if (btb_update !== 1'b0) $display("FAIL bp_upd got %b exp 0", btb_update); else n_pass++;
    n_checks++; if (btb_update_pc !== 32'h20) $display("FAIL bp_upd_hold got %h exp 20", btb_update_pc); else n_pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    tick();
    tick();
    set_resolve(32'h40, 1, 32'h200, 0, 32'h44);
    #1;
    n_checks++; if (mispredict !== 1'b1) $display("FAIL mp_dir got %b exp 1", mispredict); else n_pass++;
    tick();
    idle_inputs();
    n_checks++; if (pc_out !== 32'h200) $display("FAIL mp_pc got %h exp 200", pc_out); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL mp_bubble got %b exp 0", fetch_valid); else n_pass++;
    n_checks++; if (btb_update !== 1'b1) $display("FAIL mp_upd got %b exp 1", btb_update); else n_pass++;
    n_checks++; if (btb_update_pc !== 32'h40) $display("FAIL mp_upd_pc got %h exp 40", btb_update_pc); else n_pass++;
    n_checks++; if (btb_update_target !== 32'h200) $display("FAIL mp_upd_tgt got %h exp 200", btb_update_target); else n_pass++;
    tick();
    n_checks++; if (fetch_valid !== 1'b1) $display("FAIL mp_resume got %b exp 1", fetch_valid); else n_pass++;
    n_checks++; if (pc_out !== 32'h200) $display("FAIL mp_pc_hold got %h exp 200", pc_out); else n_pass++;
    n_checks++; if (btb_update !== 1'b0) $display("FAIL mp_upd_pulse got %b exp 0", btb_update); else n_pass++;
    tick();
    n_checks++; if (pc_out !== 32'h204) $display("FAIL mp_next got %h exp 204", pc_out); else n_pass++;
    set_resolve(32'h80, 0, 32'h0, 0, 32'h90);
    #1;
    n_checks++; if (mispredict !== 1'b1) $display("FAIL mp_nt_tgt got %b exp 1", mispredict); else n_pass++;
    resolve_pred_target = 32'h84;
    #1;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL mp_nt_ok got %b exp 0", mispredict); else n_pass++;
    set_resolve(32'h80, 1, 32'h300, 1, 32'h304);
    #1;
    n_checks++; if (mispredict !== 1'b1) $display("FAIL mp_tgt got %b exp 1", mispredict); else n_pass++;
    tick();
    set_resolve(32'h90, 0, 32'h0, 1, 32'h500);
    tick();
    idle_inputs();
    n_checks++; if (pc_out !== 32'h94) $display("FAIL mp_redir2_pc got %h exp 94", pc_out); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL mp_redir2_fv got %b exp 0", fetch_valid); else n_pass++;
    tick();
    n_checks++; if (fetch_valid !== 1'b1) $display("FAIL mp_redir2_run got %b exp 1", fetch_valid); else n_pass++;
    tick();
    n_checks++; if (pc_out !== 32'h98) $display("FAIL mp_redir2_next got %h exp 98", pc_out); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (pc_out !== 32'h4) $display("FAIL stall_pc[%0d] got %h exp 4", k, pc_out); else n_pass++;
    end
    set_resolve(32'h10, 1, 32'hFFFF_FFFC, 0, 32'h14);
    tick();
    idle_inputs();
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL stall_mp got %h exp fffffffc", pc_out); else n_pass++;
    tick();
    #1;
    n_checks++; if (pred_next_pc !== 32'h0) $display("FAIL wrap_pn got %h exp 0", pred_next_pc); else n_pass++;
    tick();
    n_checks++; if (pc_out !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc_out); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    set_resolve(32'h5C, 0, 32'h0, 1, 32'h100);
    tick();
    idle_inputs();
    stall = 1; btb_hit = 1; btb_target = 32'h500;
    #1;
    n_checks++; if (pc_out !== 32'h60) $display("FAIL sat_pc got %h exp 60", pc_out); else n_pass++;
    repeat (5) begin
      set_resolve(32'h60, 0, 32'h0, 0, 32'h64);
      tick();
    end
    set_resolve(32'h60, 1, 32'h500, 1, 32'h500);
    #1;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL sat_lo got %b exp 0", pred_taken); else n_pass++;
    tick();
    #1;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL sat_lo_rbw got %b exp 0", pred_taken); else n_pass++;
    tick();
    #1;
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL sat_lo_up got %b exp 1", pred_taken); else n_pass++;
    repeat (4) tick();
    set_resolve(32'h60, 0, 32'h0, 0, 32'h64);
    tick();
    #1;
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL sat_hi got %b exp 1", pred_taken); else n_pass++;
    tick();
    #1;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL sat_hi_dn got %b exp 0", pred_taken); else n_pass++;
    n_checks++; if (pc_out !== 32'h60) $display("FAIL sat_pc_end got %h exp 60", pc_out); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] corr;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      stall         = ($urandom_range(0, 3) == 0);
      btb_hit       = 1'($urandom_range(0, 1));
      btb_target    = 32'($urandom_range(0, 255)) << 2;
      resolve_valid = 1'($urandom_range(0, 1));
      resolve_pc    = ($urandom_range(0, 3) == 0) ? m_pc : 32'($urandom_range(0, 63)) << 2;
      resolve_taken = 1'($urandom_range(0, 1));
      resolve_target = 32'($urandom_range(0, 255)) << 2;
      corr = exp_correct();
      resolve_pred_taken  = ($urandom_range(0, 3) == 0) ? !resolve_taken : resolve_taken;
      resolve_pred_target = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) << 2 : corr;
      #1;
      n_checks++; if (pred_taken !== exp_pt()) $display("FAIL rnd_pt[%0d] got %b exp %b", n, pred_taken, exp_pt()); else n_pass++;
      n_checks++; if (pred_next_pc !== exp_pnext()) $display("FAIL rnd_pn[%0d] got %h exp %h", n, pred_next_pc, exp_pnext()); else n_pass++;
      n_checks++; if (mispredict !== exp_mp()) $display("FAIL rnd_mp[%0d] got %b exp %b", n, mispredict, exp_mp()); else n_pass++;
      model_step();
      tick();
      n_checks++; if (pc_out !== m_pc) $display("FAIL rnd_pc[%0d] got %h exp %h", n, pc_out, m_pc); else n_pass++;
      n_checks++; if (fetch_valid !== m_fv) $display("FAIL rnd_fv[%0d] got %b exp %b", n, fetch_valid, m_fv); else n_pass++;
      n_checks++; if (btb_update !== m_upd) $display("FAIL rnd_upd[%0d] got %b exp %b", n, btb_update, m_upd); else n_pass++;
      n_checks++;
      if (btb_update_pc !== m_upd_pc || btb_update_target !== m_upd_tgt)
        $display("FAIL rnd_upd_data[%0d] got %h/%h exp %h/%h", n, btb_update_pc, btb_update_target, m_upd_pc, m_upd_tgt);
      else n_pass++;
`ifdef FETCH_PERF_COUNTERS_EN
      n_checks++;
      if (perf_branches !== m_branches || perf_mispredicts !== m_mispredicts)
        $display("FAIL rnd_perf[%0d] got %0d/%0d exp %0d/%0d", n, perf_branches, perf_mispredicts, m_branches, m_mispredicts);
      else n_pass++;
`endif
    end
    idle_inputs();
  endtask

  task automatic test_perf();
    logic [31:0] exp_b, exp_m;
    do_reset();
    tick();
    stall = 1;
    set_resolve(32'h10, 1, 32'h80, 1, 32'h80);  tick();
    set_resolve(32'h14, 0, 32'h0, 1, 32'h90);   tick();
    set_resolve(32'h18, 0, 32'h0, 0, 32'h1C);   tick();
    set_resolve(32'h1C, 1, 32'hA0, 0, 32'h20);  tick();
    set_resolve(32'h20, 1, 32'hB0, 1, 32'hB0);  tick();
    idle_inputs();
`ifdef FETCH_PERF_COUNTERS_EN
    exp_b = 32'd5; exp_m = 32'd2;
`else
    exp_b = 32'd0; exp_m = 32'd0;
`endif
    n_checks++; if (perf_branches !== exp_b) $display("FAIL perf_br got %0d exp %0d", perf_branches, exp_b); else n_pass++;
    n_checks++; if (perf_mispredicts !== exp_m) $display("FAIL perf_mp got %0d exp %0d", perf_mispredicts, exp_m); else n_pass++;
    set_resolve(32'h24, 1, 32'hC0, 0, 32'h28);
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    n_checks++; if (perf_branches !== 32'd0) $display("FAIL perf_br_rst got %0d exp 0", perf_branches); else n_pass++;
    n_checks++; if (perf_mispredicts !== 32'd0) $display("FAIL perf_mp_rst got %0d exp 0", perf_mispredicts); else n_pass++;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_btb_predict();
    test_mispredict();
    test_stall();
    test_saturation();
    test_random();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage next-PC generator.
- Holds the fetch PC register and drives it to the branch target buffer lookup (pc_out -> pc_in).
- Consumes the BTB hit and target, combined with a bimodal table of 2-bit saturating direction counters, to choose the next PC.
- Takes branch resolution from the MEM stage, detects mispredicts, redirects fetch and emits BTB update requests.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PHT_BITS, 6, log2 of direction-counter entries; index = pc[PHT_BITS+1:2].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; downstream not accepting.
- btb_hit  input  1  BTB hit for pc_out.
- btb_target  input  32  BTB predicted target for pc_out.
- resolve_valid  input  1  one branch resolved this cycle (MEM stage).
- resolve_pc  input  32  PC of the resolved branch.
- resolve_taken  input  1  actual direction.
- resolve_target  input  32  actual taken target.
- resolve_pred_taken  input  1  prediction carried down the pipe with the branch.
- resolve_pred_target  input  32  predicted next PC carried down the pipe.
- pc_out  output  32  current fetch PC.
- fetch_valid  output  1  pc_out is a valid fetch this cycle.
- pred_taken  output  1  prediction for pc_out; travels with the instruction.
- pred_next_pc  output  32  predicted next PC for pc_out.
- mispredict  output  1  flush younger instructions (combinational).
- btb_update  output  1  write request to the BTB.
- btb_update_pc  output  32  branch PC to write.
- btb_update_target  output  32  target to write.
- perf_branches  output  32  resolved-branch count (optional feature).
- perf_mispredicts  output  32  mispredict count (optional feature).

Behaviour:
- Reset (synchronous):
  - pc_out=RESET_PC; all counters=2'b01 (weakly not-taken); state=BOOT.
  - fetch_valid=0, mispredict=0, btb_update=0, perf counters=0.
  - Reset mid-operation discards any pending redirect.
- Prediction (combinational from pc_out):
  - pred_taken = btb_hit && cnt[idx(pc_out)][1].
  - pred_next_pc = pred_taken ? btb_target : pc_out+4.
- Mispredict:
  - mispredict = resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target != resolve_pred_target)).
  - A not-taken branch with a wrong pred_target also counts as a mispredict: compare resolve_pred_target against resolve_pc+4.
  - Correct PC = resolve_taken ? resolve_target : resolve_pc+4.
- Next PC, evaluated at each edge in priority order:
  - reset: RESET_PC.
  - mispredict: correct PC.
  - stall: hold.
  - fetch_valid=1: pred_next_pc.
  - otherwise: hold.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- FSM states:
  - BOOT: fetch_valid=0; next cycle goes to RUN.
  - RUN: fetch_valid=1; a mispredict goes to REDIRECT.
  - REDIRECT: fetch_valid=0 for exactly one cycle while the new PC propagates through the BTB; next cycle goes to RUN. A mispredict seen while in REDIRECT reloads the PC and stays in REDIRECT one more cycle.
- Mispredict overrides stall in the same cycle.
- Counter update, on resolve_valid:
  - Index is idx(resolve_pc).
  - Taken: increment, saturating at 3. Not-taken: decrement, saturating at 0.
  - Lookup and update to the same index in one cycle: lookup sees the old value (read-before-write).
- BTB update (registered, one-cycle pulse the cycle after resolution):
  - btb_update=1 when resolve_valid && resolve_taken.
  - btb_update_pc=resolve_pc; btb_update_target=resolve_target.
  - Outputs hold their last values when btb_update=0.
- Only one resolution per cycle; resolve_valid is ignored during reset.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - perf_branches increments on every resolve_valid.
  - perf_mispredicts increments on every mispredict.
  - Both are 32-bit, wrap on overflow and clear on reset.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release, RESET_PC=0, no stall, no BTB hits -> cycle 1 fetch_valid=0; then pc_out=0,4,8,12 with fetch_valid=1.
- btb_hit=1, btb_target=0x100 at pc_out=0x20, counter at reset value 01 -> pred_taken=0, next pc 0x24. After two taken resolutions of 0x20 (counter reaches 11) -> pred_taken=1, next pc 0x100.
- resolve_valid with pc=0x40, taken=1, target=0x200, pred_taken=0 -> mispredict=1 that cycle; next pc_out=0x200 with fetch_valid=0 for one cycle; btb_update=1 with 0x40/0x200 the following cycle.
- stall=1 and a mispredict in the same cycle -> pc_out loads the correct PC. stall=1 alone for 3 cycles -> pc_out constant.
- Saturation: four not-taken resolutions of 0x60 -> counter 00; a fifth stays 00. Four taken -> 11, then stays 11.
- With FETCH_PERF_COUNTERS_EN: 5 resolutions including 2 mispredicts -> perf_branches=5, perf_mispredicts=2; a reset mid-count -> both 0.
